// File: rtl/inst_rom_pkg.sv
// rtl/inst_rom_pkg.sv - shared types and constants for the instruction ROM and its loader
//
// Purpose: loader state encoding, the NOP word returned on masked fetches,
//          and the chip-enable levels used by the fetch path.
// Ports:   none (package).
package inst_rom_pkg;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_BYTE   = 2'd1,
    LD_COMMIT = 2'd2,
    LD_DONE   = 2'd3
  } ld_state_t;

  localparam int          INST_W       = 32;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;

endpackage

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - byte-serial loader that assembles words and writes them into the ROM array
//
// Purpose: accepts bytes MSB-first over a valid/ready handshake, packs four
//          into a word and issues one write per word, starting at word 0.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   ld_start        pulse in IDLE: begin a load of ld_words words
//   ld_words        requested word count, clamped to the array depth
//   ld_valid        byte valid
//   ld_byte         byte data
//   ld_ready        byte can be accepted this cycle (pure state decode)
//   ld_busy         load in progress
//   ld_done         one-cycle completion pulse
//   we, waddr, wdata  array write port
module inst_rom_loader
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_words,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  ld_state_t         state, next_state;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   ptr_q;
  logic [1:0]        bcnt_q;
  logic [31:0]       asm_q;

  logic [ADDR_W:0]   clamped;
  logic [ADDR_W:0]   ptr_next;
  logic              accept;
  logic              start_ok;

  assign clamped  = (ld_words > MAX_WORDS) ? MAX_WORDS : ld_words;
  assign ptr_next = ptr_q + (ADDR_W+1)'(1);
  assign accept   = ld_valid && (state == LD_BYTE);
  assign start_ok = ld_start && (state == LD_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LD_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      LD_IDLE: begin
        if (ld_start) begin
          next_state = (clamped == '0) ? LD_DONE : LD_BYTE;
        end
      end
      LD_BYTE: begin
        if (accept && (bcnt_q == 2'd3)) begin
          next_state = LD_COMMIT;
        end
      end
      LD_COMMIT: begin
        next_state = (ptr_next == count_q) ? LD_DONE : LD_BYTE;
      end
      LD_DONE: begin
        next_state = LD_IDLE;
      end
      default: begin
        next_state = LD_IDLE;
      end
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    ld_busy  = 1'b1;
    ld_done  = 1'b0;
    we       = 1'b0;
    case (state)
      LD_IDLE:   ld_busy  = 1'b0;
      LD_BYTE:   ld_ready = 1'b1;
      LD_COMMIT: we       = 1'b1;
      LD_DONE:   ld_done  = 1'b1;
      default:   ld_busy  = 1'b0;
    endcase
  end

  // Reset clears the partial assembly so an aborted word never leaks into a later load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ptr_q   <= '0;
      bcnt_q  <= 2'd0;
      asm_q   <= ZERO_WORD;
    end else begin
      if (start_ok) begin
        count_q <= clamped;
        ptr_q   <= '0;
        bcnt_q  <= 2'd0;
      end
      if (accept) begin
        asm_q  <= {asm_q[23:0], ld_byte};
        bcnt_q <= bcnt_q + 2'd1;
      end
      if (state == LD_COMMIT) begin
        ptr_q <= ptr_next;
      end
    end
  end

  assign waddr = ptr_q[ADDR_W-1:0];
  assign wdata = asm_q;

endmodule

// File: rtl/inst_rom.sv
// rtl/inst_rom.sv - instruction memory with combinational fetch port and run-time byte loader
//
// Purpose: holds the instruction array, answers core fetches in the same
//          cycle, and returns NOP while disabled, loading, or out of range.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   ce              fetch enable (core rom_ce_o)
//   addr            fetch byte address (core rom_addr_o); bits [1:0] ignored
//   inst            fetched instruction (core rom_data_i)
//   ld_start, ld_words, ld_valid, ld_byte   loader control and byte stream
//   ld_ready, ld_busy, ld_done              loader status
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       addr,
  output logic [DATA_W-1:0] inst,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_words,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              in_range;
  logic              unused_addr_lsbs;

  // One write port, one asynchronous read port, no reset: maps onto RAM.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  inst_rom_loader #(
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_words (ld_words),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata)
  );

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign in_range         = (addr[31:ADDR_W+2] == '0);
  assign unused_addr_lsbs = ^addr[1:0];

  // Fetches are masked for the whole load, including words already committed.
  always_comb begin
    inst = ZERO_WORD;
    if ((ce == CHIP_ENABLE) && !ld_busy && in_range) begin
      inst = mem[addr[ADDR_W+1:2]];
    end
  end

endmodule

// File: tb/tb_inst_rom.sv
// tb/tb_inst_rom.sv - self-checking bench for inst_rom with randomized loads and fetches
module tb_inst_rom;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ce = 1'b0;
  logic [31:0]       addr = 32'h0;
  logic [31:0]       inst;
  logic              ld_start = 1'b0;
  logic [ADDR_W:0]   ld_words = '0;
  logic              ld_valid = 1'b0;
  logic [7:0]        ld_byte = 8'h00;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;

  logic [31:0] exp_mem [DEPTH];
  bit          exp_ok  [DEPTH];
  logic [31:0] tx_words [$];

  int n_vec = 0;
  int n_err = 0;

  inst_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .addr     (addr),
    .inst     (inst),
    .ld_start (ld_start),
    .ld_words (ld_words),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(ld_ready), 32'd0);
    check({tag, "_busy"},  32'(ld_busy),  32'd0);
    check({tag, "_done"},  32'(ld_done),  32'd0);
  endtask

  // Expected fetch result from the model; in-range words never written are skipped.
  task automatic check_fetch(input string tag, input logic [31:0] a);
    logic [31:0] e;
    int          idx;
    ce   = 1'b1;
    addr = a;
    #1;
    if (a[31:ADDR_W+2] != '0) begin
      check(tag, inst, 32'h0);
    end else begin
      idx = int'(a[ADDR_W+1:2]);
      if (exp_ok[idx]) begin
        e = exp_mem[idx];
        check(tag, inst, e);
      end
    end
    ce = 1'b0;
  endtask

  // Drives one load of tx_words. abort_at >= 0 resets the block once that many
  // bytes have been accepted; poke re-pulses ld_start while bytes are flowing.
  task automatic run_load(input int req, input bit gaps, input int abort_at, input bit poke);
    int          n;
    int          got;
    int          cyc;
    bit          commit;
    logic [31:0] w;
    n = (req > DEPTH) ? DEPTH : req;
    @(negedge clk);
    ld_start = 1'b1;
    ld_words = (ADDR_W+1)'(req);
    @(negedge clk);
    ld_start = 1'b0;
    cyc      = 1;
    got      = 0;
    commit   = 1'b0;
    while (got < 4 * n || commit) begin
      if (cyc > 40 * n + 50) begin
        check("load_timeout", 32'(cyc), 32'd0);
        return;
      end
      check("ld_ready", 32'(ld_ready), commit ? 32'd0 : 32'd1);
      check("ld_busy",  32'(ld_busy),  32'd1);
      check("ld_done",  32'(ld_done),  32'd0);
      ce   = 1'b1;
      addr = {20'h0, 10'($urandom), 2'($urandom)};
      #1;
      check("mask_busy", inst, 32'h0);
      ce = 1'b0;
      if (got == abort_at && !commit) begin
        ld_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check_idle("abort");
        check("abort_inst", inst, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (poke && cyc == 3) begin
        ld_start = 1'b1;
        ld_words = (ADDR_W+1)'(5);
      end
      ld_byte = 8'($urandom);
      if (commit) begin
        exp_mem[got/4 - 1] = tx_words[got/4 - 1];
        exp_ok[got/4 - 1]  = 1'b1;
        ld_valid           = 1'($urandom % 2);
        commit             = 1'b0;
      end else begin
        ld_valid = gaps ? 1'($urandom % 2) : 1'b1;
        if (ld_valid) begin
          w       = tx_words[got/4];
          ld_byte = w[31 - 8*(got%4) -: 8];
          got++;
          if (got % 4 == 0) commit = 1'b1;
        end
      end
      @(negedge clk);
      ld_start = 1'b0;
      ld_valid = 1'b0;
      cyc++;
    end
    check("done_pulse", 32'(ld_done),  32'd1);
    check("done_busy",  32'(ld_busy),  32'd1);
    check("done_ready", 32'(ld_ready), 32'd0);
    if (!gaps) check("done_cycle", 32'(cyc), 32'(5 * n + 1));
    ld_valid = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
    check_idle("after_done");
  endtask

  task automatic fill_words(input int n);
    tx_words.delete();
    for (int i = 0; i < n; i++) tx_words.push_back($urandom);
  endtask

  initial begin
    int          n;
    logic [31:0] old1;
    for (int i = 0; i < DEPTH; i++) exp_ok[i] = 1'b0;

    repeat (2) @(negedge clk);
    check_idle("reset");
    #1;
    check("reset_inst", inst, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Two-word program, valid held high.
    tx_words.delete();
    tx_words.push_back(32'h3401_0020);
    tx_words.push_back(32'h3402_FFFF);
    run_load(2, 1'b0, -1, 1'b0);
    ce = 1'b1;
    addr = 32'd0; #1; check("w0_addr0", inst, 32'h3401_0020);
    addr = 32'd4; #1; check("w1_addr4", inst, 32'h3402_FFFF);
    addr = 32'd5; #1; check("w1_addr5", inst, 32'h3402_FFFF);
    ce = 1'b0;

    // Same program with random gaps in ld_valid.
    run_load(2, 1'b1, -1, 1'b0);
    ce = 1'b1;
    addr = 32'd0; #1; check("gap_w0", inst, 32'h3401_0020);
    addr = 32'd7; #1; check("gap_w1", inst, 32'h3402_FFFF);
    ce = 1'b0;

    // Oversized request clamps to the full array.
    fill_words(DEPTH);
    run_load($urandom_range(DEPTH + 1, 2 * DEPTH - 1), 1'b0, -1, 1'b0);
    check_fetch("clamp_first", 32'd0);
    check_fetch("clamp_last", 32'(4 * (DEPTH - 1) + 3));
    for (int i = 0; i < 64; i++) check_fetch("clamp_rand", {20'h0, 10'($urandom), 2'($urandom)});

    // Short random loads with gaps, some with an ignored ld_start during BYTE.
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 8);
      fill_words(n);
      run_load(n, 1'b1, -1, it[0]);
      for (int i = 0; i < 16; i++) check_fetch("rand_load", {26'h0, 4'($urandom), 2'($urandom)});
    end

    // Zero-count load leaves the array untouched.
    run_load(0, 1'b0, -1, 1'b0);
    for (int i = 0; i < 12; i++) check_fetch("zero_keep", 32'(4 * i));

    // Reset after word 0 committed and two bytes of word 1 accepted.
    old1 = exp_mem[1];
    fill_words(2);
    run_load(2, 1'b1, 6, 1'b0);
    #1;
    check_idle("post_abort");
    check_fetch("abort_w0_new", 32'd0);
    ce = 1'b1; addr = 32'd4; #1; check("abort_w1_old", inst, old1); ce = 1'b0;
    fill_words(1);
    run_load(1, 1'b0, -1, 1'b0);
    check_fetch("reload_w0", 32'd0);

    // Fetch masking outside a load.
    check_fetch("oor_1000", 32'h0000_1000);
    for (int i = 0; i < 8; i++) check_fetch("oor_rand", {20'($urandom_range(1, 20'hFFFFF)), 12'($urandom)});
    ce = 1'b0; addr = 32'd0; #1; check("ce_off", inst, 32'h0);
    addr = 32'd4; #1; check("ce_off4", inst, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
